// File: rtl/shift_counter_pkg.sv
// shift_counter_pkg: shared encodings and seed pattern for the shift-register counter
package shift_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    // Single LSB set; legal in both ring and Johnson modes for any width
    function automatic logic [63:0] seed(input int width);
        return (width > 0) ? 64'd1 : 64'd0;
    endfunction

endpackage

// File: rtl/shift_pattern_decode.sv
// shift_pattern_decode: legality check and sequence index of a ring/Johnson pattern
module shift_pattern_decode
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] pattern,
    input  logic             mode,
    output logic             legal,
    output logic [IW-1:0]    idx
);

    logic [WIDTH-1:0] msb_mask;
    logic [WIDTH-1:0] lsb_mask;
    logic             msb_run;
    logic             lsb_run;
    int               k;
    int               p;

    always_comb begin
        k = 0;
        p = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pattern[i]) begin
                k = k + 1;
                p = i;
            end
        end
        msb_mask = ~({WIDTH{1'b1}} >> k);
        lsb_mask = ~({WIDTH{1'b1}} << k);
        msb_run  = (pattern == msb_mask);
        lsb_run  = (pattern == lsb_mask);
        // MSB-contiguous wins so that all-zeros and all-ones decode on the filling half
        legal = (mode == MODE_JOHNSON) ? (msb_run || lsb_run) : (k == 1);
        idx   = (mode == MODE_RING) ? ((p == 0) ? '0 : IW'(WIDTH - p)) :
                msb_run             ? IW'(k + 1) :
                (k == 1)            ? '0 : IW'(2 * WIDTH + 1 - k);
    end

endmodule

// File: rtl/shift_counter_gen.sv
// shift_counter_gen: run-time selectable ring/Johnson counter with load, self-correction and index
module shift_counter_gen
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [IW-1:0]    idx,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] SEED = WIDTH'(seed(WIDTH));

    logic [WIDTH-1:0] count_q, count_d, step;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             cnt_legal, ld_legal;
    logic [IW-1:0]    ld_idx;
    logic [IW-1:0]    last_idx;

    shift_pattern_decode #(.WIDTH(WIDTH)) u_cnt_dec (
        .pattern(count_q),
        .mode   (mode),
        .legal  (cnt_legal),
        .idx    (idx)
    );

    shift_pattern_decode #(.WIDTH(WIDTH)) u_ld_dec (
        .pattern(load_val),
        .mode   (mode),
        .legal  (ld_legal),
        .idx    (ld_idx)
    );

    always_comb begin
        last_idx = (mode == MODE_JOHNSON) ? IW'(2 * WIDTH - 1) : IW'(WIDTH - 1);
        // Johnson feedback is the inverted outgoing bit; ring feeds it back unchanged
        step     = (dir == DIR_DOWN) ? {count_q[WIDTH-2:0], count_q[WIDTH-1] ^ mode}
                                     : {count_q[0] ^ mode, count_q[WIDTH-1:1]};
        count_d  = load       ? (ld_legal ? load_val : SEED) :
                   !cnt_legal ? SEED :
                   en         ? step : count_q;
        err_d    = load ? !ld_legal : !cnt_legal;
        wrap_d   = !load && cnt_legal && en &&
                   ((dir == DIR_DOWN) ? (idx == '0) : (idx == last_idx));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= SEED;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// tb_shift_counter_gen: directed vector table plus reset/mode-switch sequences for WIDTH=4
module tb_shift_counter_gen;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic       en;
        logic       dir;
        logic       mode;
        logic       load;
        logic [3:0] lv;
        logic [3:0] c;
        logic [2:0] i;
        logic       w;
        logic       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic [2:0] idx;
    logic       wrap, err;

    int   n_chk = 0;
    int   n_pass = 0;
    vec_t vq[$];

    shift_counter_gen #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dir     (dir),
        .mode    (mode),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .idx     (idx),
        .wrap    (wrap),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic [2:0] i,
                             input logic w, input logic e);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " idx"}, 32'(idx), 32'(i));
        chk({tag, " wrap"}, 32'(wrap), 32'(w));
        chk({tag, " err"}, 32'(err), 32'(e));
    endtask

    task automatic add(input logic e_n, input logic d, input logic m, input logic ld,
                       input logic [3:0] lv, input logic [3:0] c, input logic [2:0] i,
                       input logic w, input logic e);
        vec_t v;
        v = '{en: e_n, dir: d, mode: m, load: ld, lv: lv, c: c, i: i, w: w, e: e};
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        en = v.en; dir = v.dir; mode = v.mode; load = v.load; load_val = v.lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ring up from SEED
        add(H, L, L, L, 4'b0000, 4'b1000, 3'd1, L, L);
        add(H, L, L, L, 4'b0000, 4'b0100, 3'd2, L, L);
        add(H, L, L, L, 4'b0000, 4'b0010, 3'd3, L, L);
        add(H, L, L, L, 4'b0000, 4'b0001, 3'd0, H, L);
        // Johnson full cycle
        add(H, L, H, L, 4'b0000, 4'b0000, 3'd1, L, L);
        add(H, L, H, L, 4'b0000, 4'b1000, 3'd2, L, L);
        add(H, L, H, L, 4'b0000, 4'b1100, 3'd3, L, L);
        add(H, L, H, L, 4'b0000, 4'b1110, 3'd4, L, L);
        add(H, L, H, L, 4'b0000, 4'b1111, 3'd5, L, L);
        add(H, L, H, L, 4'b0000, 4'b0111, 3'd6, L, L);
        add(H, L, H, L, 4'b0000, 4'b0011, 3'd7, L, L);
        add(H, L, H, L, 4'b0000, 4'b0001, 3'd0, H, L);
        // Johnson down across the boundary
        add(H, H, H, L, 4'b0000, 4'b0011, 3'd7, H, L);
        add(H, H, H, L, 4'b0000, 4'b0111, 3'd6, L, L);
        // loads: legal, illegal, load beats en
        add(L, L, H, H, 4'b1100, 4'b1100, 3'd3, L, L);
        add(L, L, H, H, 4'b0101, 4'b0001, 3'd0, L, H);
        add(H, L, H, H, 4'b1000, 4'b1000, 3'd2, L, L);
        // ring step, then switch to Johnson with an illegal count and en=0
        add(H, L, L, L, 4'b0000, 4'b0100, 3'd2, L, L);
        add(L, L, H, L, 4'b0000, 4'b0001, 3'd0, L, H);
        add(L, L, L, H, 4'b1000, 4'b1000, 3'd1, L, L);
        // Johnson-legal count survives the switch
        add(L, L, H, L, 4'b0000, 4'b1000, 3'd2, L, L);
        // illegal ring load, ring down wrap, hold
        add(L, L, L, H, 4'b0110, 4'b0001, 3'd0, L, H);
        add(H, H, L, L, 4'b0000, 4'b0010, 3'd3, H, L);
        add(H, H, L, L, 4'b0000, 4'b0100, 3'd2, L, L);
        add(L, H, L, L, 4'b0000, 4'b0100, 3'd2, L, L);
        // Johnson all-zeros and all-ones are legal loads
        add(L, L, H, H, 4'b0000, 4'b0000, 3'd1, L, L);
        add(L, L, H, H, 4'b1111, 4'b1111, 3'd5, L, L);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'b0001, 3'd0, L, L);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            drive(vq[k]);
            check_all($sformatf("vec%0d", k), vq[k].c, vq[k].i, vq[k].w, vq[k].e);
        end

        // idx follows the mode input before any edge
        @(negedge clk);
        load = 1'b1; load_val = 4'b1000; mode = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        chk("ring1000 idx", 32'(idx), 32'd1);
        mode = 1'b1; load = 1'b0;
        #1;
        chk("switch idx now", 32'(idx), 32'd2);

        // reset between edges while a Johnson step with wrap pending
        @(negedge clk);
        load = 1'b1; load_val = 4'b0011; mode = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;
        load = 1'b0; en = 1'b1; dir = 1'b0;
        @(posedge clk);
        #1;
        check_all("pre-rst wrap", 4'b0001, 3'd0, H, L);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre-rst count", 32'(count), 32'(4'b1000));
        #2;
        rst = 1'b1;
        #1;
        check_all("async rst", 4'b0001, 3'd0, L, L);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post-rst step", 4'b0000, 3'd1, L, L);

        // ring at 0100 switched to Johnson with en=0
        @(negedge clk);
        mode = 1'b0; load = 1'b1; load_val = 4'b0100; en = 1'b0;
        @(posedge clk);
        #1;
        mode = 1'b1; load = 1'b0;
        @(posedge clk);
        #1;
        check_all("switch correct", 4'b0001, 3'd0, L, H);
        @(posedge clk);
        #1;
        chk("err one cycle", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
